data_mem_stage: RTL and testbench
=================================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, number of DATA_W words; power of two.
REQ-003 SHALL have parameter LATENCY, default 2, edges from acceptance to response (legal 1..8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  stage can accept a request.
REQ-008 icode  input  4  Y86 instruction code of request.
REQ-009 valA  input  DATA_W  store data / pop-ret address.
REQ-010 valE  input  DATA_W  computed address for rmmovq, mrmovq, call, pushq.
REQ-011 valP  input  DATA_W  return address stored by call.
REQ-012 out_valid  output  1  response present.
REQ-013 out_ready  input  1  downstream accepts response.
REQ-014 out_icode  output  4  icode of the responding transaction.
REQ-015 valM  output  DATA_W  read data; 0 for non-reads and errors.
REQ-016 mem_err  output  1  address error on responding transaction.
REQ-017 dbg_word  output  DATA_W  word written or read by responding transaction; 0 otherwise.

Function
REQ-018 Decode: writes 4'h4 rmmovq (addr valE, data valA), 4'h8 call (addr valE, data valP), 4'hA pushq (addr valE, data valA); reads 4'h5 mrmovq (addr valE), 4'h9 ret (addr valA), 4'hB popq (addr valA); all other icodes no memory access.
REQ-019 Addresses are byte addresses; word index = addr >> 3; error if addr[2:0] != 0 or addr >= DEPTH*8 (full DATA_W compare, no truncation/wrap).
REQ-020 FSM states IDLE, WAIT, RESP; in_ready = 1 only in IDLE.
REQ-021 Accept on edge with in_valid && in_ready; latch icode, address, data; LATENCY=1 -> RESP, else -> WAIT with counter = LATENCY-1.
REQ-022 WAIT decrements counter each edge; at counter==1 edge -> RESP.
REQ-023 Write commits to array on acceptance edge; no write on error or non-write icode.
REQ-024 Read samples array on edge entering RESP; a read accepted after a write to same index returns new data.
REQ-025 RESP: out_valid=1; out_icode, valM, mem_err, dbg_word held stable until edge with out_ready=1, then -> IDLE, out_valid=0.
REQ-026 Non-memory icodes traverse same FSM/latency with valM=0, mem_err=0, dbg_word=0.
REQ-027 Error transactions: valM=0, dbg_word=0, mem_err=1, array unchanged.
REQ-028 Back-to-back throughput: one transaction per LATENCY+1 cycles minimum; in_valid ignored outside IDLE.

Reset
REQ-029 rst=1 forces immediately: state IDLE, counter 0, out_valid 0, out_icode 0, valM 0, mem_err 0, dbg_word 0; in_ready 1 after release.
REQ-030 Reset mid-WAIT/RESP discards response; a write committed on the acceptance edge stays committed; array contents never cleared by reset.

Verification
REQ-031 LATENCY=2: rmmovq valE=0x10 valA=0xDEAD -> out_valid 2 edges after accept, mem_err 0, dbg_word 0xDEAD; then mrmovq valE=0x10 -> valM 0xDEAD.
REQ-032 call valE=0x1F8 valP=0x40, then ret valA=0x1F8 -> valM 0x40; pushq/popq pair at 0x100 with 0x1234 -> popq valM 0x1234.
REQ-033 mrmovq valE=0x2004 (misaligned) and valE=0x2000 (=DEPTH*8) -> mem_err 1, valM 0; prior word at 0x0 unchanged.
REQ-034 Hold out_ready=0 for 5 cycles in RESP -> out_valid and valM stable, in_ready 0, new in_valid ignored.
REQ-035 Assert rst during WAIT of pushq valE=0x8 valA=0x77 -> outputs zero at once, no response; later mrmovq 0x8 -> valM 0x77.
REQ-036 icode 4'h6 (OPq) -> response after LATENCY edges with valM 0, mem_err 0; repeat with LATENCY=1 and LATENCY=8.

Source files
------------

// File: rtl/data_mem_stage.sv
// Y86 data-memory stage: decodes the memory op of an accepted request, commits writes
// immediately, and returns a registered response after LATENCY edges with a ready/valid handshake.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// WAIT   | request latched, counting down to the response
// RESP   | response presented, held until out_ready
module data_mem_stage #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] valM,
    output logic              mem_err,
    output logic [DATA_W-1:0] dbg_word
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [3:0]         r_icode;
    logic [IDX_W-1:0]   r_idx;
    logic               r_rd, r_wr, r_err;
    logic [DATA_W-1:0]  r_wdata;

    logic [3:0]         r_out_icode;
    logic [DATA_W-1:0]  r_valM, r_dbg;
    logic               r_mem_err;

    logic               w_is_wr, w_is_rd, w_err, w_accept, w_load_resp, w_leave_resp;
    logic [DATA_W-1:0]  w_addr, w_wdata;
    logic [IDX_W-1:0]   w_idx;

    logic [3:0]         w_src_icode;
    logic [IDX_W-1:0]   w_src_idx;
    logic               w_src_rd, w_src_wr, w_src_err;
    logic [DATA_W-1:0]  w_src_wdata, w_rdata;

    always_comb begin
        w_is_wr = 1'b0;
        w_is_rd = 1'b0;
        w_addr  = valE;
        w_wdata = valA;
        case (icode)
            4'h4: w_is_wr = 1'b1;
            4'h8: begin
                w_is_wr = 1'b1;
                w_wdata = valP;
            end
            4'hA: w_is_wr = 1'b1;
            4'h5: w_is_rd = 1'b1;
            4'h9, 4'hB: begin
                w_is_rd = 1'b1;
                w_addr  = valA;
            end
            default: ;
        endcase
    end

    // Range check on the whole address so out-of-range bytes never alias onto low words.
    assign w_err = (w_is_wr || w_is_rd) &&
                   ((w_addr[2:0] != 3'b000) || ((w_addr >> 3) >= DATA_W'(DEPTH)));
    assign w_idx = w_addr[IDX_W+2:3];

    assign w_accept     = in_valid && (r_state == S_IDLE);
    assign w_load_resp  = (w_accept && (LATENCY == 1)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_leave_resp = (r_state == S_RESP) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With LATENCY=1 the response is built on the acceptance edge straight from the decode.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_src_icode = icode;
            w_src_idx   = w_idx;
            w_src_rd    = w_is_rd;
            w_src_wr    = w_is_wr;
            w_src_err   = w_err;
            w_src_wdata = w_wdata;
        end else begin
            w_src_icode = r_icode;
            w_src_idx   = r_idx;
            w_src_rd    = r_rd;
            w_src_wr    = r_wr;
            w_src_err   = r_err;
            w_src_wdata = r_wdata;
        end
        w_rdata = r_mem[w_src_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_is_wr && !w_err) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_icode     <= 4'd0;
            r_idx       <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_out_icode <= 4'd0;
            r_valM      <= '0;
            r_mem_err   <= 1'b0;
            r_dbg       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_icode <= icode;
                r_idx   <= w_idx;
                r_rd    <= w_is_rd;
                r_wr    <= w_is_wr;
                r_err   <= w_err;
                r_wdata <= w_wdata;
            end
            if (w_load_resp) begin
                r_out_icode <= w_src_icode;
                r_mem_err   <= w_src_err;
                r_valM      <= (w_src_rd && !w_src_err) ? w_rdata : '0;
                if (w_src_err)
                    r_dbg <= '0;
                else if (w_src_rd)
                    r_dbg <= w_rdata;
                else if (w_src_wr)
                    r_dbg <= w_src_wdata;
                else
                    r_dbg <= '0;
            end else if (w_leave_resp) begin
                r_out_icode <= 4'd0;
                r_mem_err   <= 1'b0;
                r_valM      <= '0;
                r_dbg       <= '0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_RESP);
    assign out_icode = r_out_icode;
    assign valM      = r_valM;
    assign mem_err   = r_mem_err;
    assign dbg_word  = r_dbg;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: three instances at LATENCY 2 (main), 1 and 8,
// sharing clock, reset and request fields, each with its own handshake.
module tb_data_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic [2:0]  iv, ordy;
    logic [2:0]  ir, ov, me;
    logic [3:0]  oi [3];
    logic [63:0] vm [3];
    logic [63:0] dw [3];

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    data_mem_stage #(.DATA_W(64), .DEPTH(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .icode(icode),
        .valA(valA), .valE(valE), .valP(valP), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_icode(oi[0]), .valM(vm[0]), .mem_err(me[0]), .dbg_word(dw[0]));

    data_mem_stage #(.DATA_W(64), .DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .icode(icode),
        .valA(valA), .valE(valE), .valP(valP), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_icode(oi[1]), .valM(vm[1]), .mem_err(me[1]), .dbg_word(dw[1]));

    data_mem_stage #(.DATA_W(64), .DEPTH(1024), .LATENCY(8)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .icode(icode),
        .valA(valA), .valE(valE), .valP(valP), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_icode(oi[2]), .valM(vm[2]), .mem_err(me[2]), .dbg_word(dw[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance k; lat counts edges from acceptance (inclusive) to out_valid.
    task automatic start(input int k, input logic [3:0] ic, input logic [63:0] a,
                         input logic [63:0] e, input logic [63:0] p, output int l);
        icode = ic; valA = a; valE = e; valP = p;
        iv[k] = 1'b1;
        tick();
        iv[k] = 1'b0;
        l = 1;
        while (!ov[k] && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic finish_resp(input int k, input string tag);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        chk({tag, "_done"}, {63'd0, ov[k]}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; iv = '0; ordy = '0;
        icode = 4'h0; valA = '0; valE = '0; valP = '0;
        repeat (2) tick();
        chk("rst_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("rst_valM", vm[0], 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {63'd0, ir[0]}, 64'd1);
        chk("rst_out_icode", {60'd0, oi[0]}, 64'd0);
        chk("rst_dbg", dw[0], 64'd0);

        // rmmovq 0x10 <- 0xDEAD: WAIT one edge after acceptance, then RESP
        icode = 4'h4; valA = 64'hDEAD; valE = 64'h10; valP = 64'h0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        chk("rm_wait_ov", {63'd0, ov[0]}, 64'd0);
        chk("rm_wait_ir", {63'd0, ir[0]}, 64'd0);
        tick();
        chk("rm_resp_ov", {63'd0, ov[0]}, 64'd1);
        chk("rm_err", {63'd0, me[0]}, 64'd0);
        chk("rm_dbg", dw[0], 64'hDEAD);
        chk("rm_valM", vm[0], 64'd0);
        chk("rm_icode", {60'd0, oi[0]}, 64'h4);
        finish_resp(0, "rm");

        start(0, 4'h5, 64'h0, 64'h10, 64'h0, lat);
        chk("mr_lat", 64'(lat), 64'd2);
        chk("mr_valM", vm[0], 64'hDEAD);
        chk("mr_dbg", dw[0], 64'hDEAD);
        finish_resp(0, "mr");

        // call/ret and pushq/popq; addresses for the pop side come from valA
        start(0, 4'h8, 64'h5, 64'h1F8, 64'h40, lat);
        chk("call_dbg", dw[0], 64'h40);
        finish_resp(0, "call");
        start(0, 4'h9, 64'h1F8, 64'h0, 64'h0, lat);
        chk("ret_valM", vm[0], 64'h40);
        chk("ret_icode", {60'd0, oi[0]}, 64'h9);
        finish_resp(0, "ret");
        start(0, 4'hA, 64'h1234, 64'h100, 64'h0, lat);
        chk("push_dbg", dw[0], 64'h1234);
        finish_resp(0, "push");
        start(0, 4'hB, 64'h100, 64'h10, 64'h0, lat);
        chk("pop_valM", vm[0], 64'h1234);
        finish_resp(0, "pop");

        // address errors; word 0 must survive aliasing-style writes
        start(0, 4'h4, 64'hAAAA5555, 64'h0, 64'h0, lat);
        finish_resp(0, "w0");
        start(0, 4'h5, 64'h0, 64'h2004, 64'h0, lat);
        chk("mis_err", {63'd0, me[0]}, 64'd1);
        chk("mis_valM", vm[0], 64'd0);
        chk("mis_dbg", dw[0], 64'd0);
        finish_resp(0, "mis");
        start(0, 4'h5, 64'h0, 64'h2000, 64'h0, lat);
        chk("oor_err", {63'd0, me[0]}, 64'd1);
        chk("oor_valM", vm[0], 64'd0);
        finish_resp(0, "oor");
        start(0, 4'h4, 64'hBAD, 64'h2000, 64'h0, lat);
        chk("oorw_err", {63'd0, me[0]}, 64'd1);
        chk("oorw_dbg", dw[0], 64'd0);
        finish_resp(0, "oorw");
        start(0, 4'hA, 64'hBAD2, 64'h4, 64'h0, lat);
        chk("misw_err", {63'd0, me[0]}, 64'd1);
        finish_resp(0, "misw");
        start(0, 4'h5, 64'h0, 64'h0, 64'h0, lat);
        chk("w0_kept", vm[0], 64'hAAAA5555);
        finish_resp(0, "w0r");

        // hold RESP with out_ready low while a write to 0x10 is offered
        start(0, 4'h5, 64'h0, 64'h10, 64'h0, lat);
        icode = 4'h4; valA = 64'hBEEF; valE = 64'h10;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ov", {63'd0, ov[0]}, 64'd1);
            chk("hold_valM", vm[0], 64'hDEAD);
            chk("hold_ir", {63'd0, ir[0]}, 64'd0);
        end
        iv[0] = 1'b0;
        finish_resp(0, "hold");
        chk("hold_ir_after", {63'd0, ir[0]}, 64'd1);
        tick();
        chk("hold_no_txn", {63'd0, ov[0]}, 64'd0);
        start(0, 4'h5, 64'h0, 64'h10, 64'h0, lat);
        chk("hold_mem_kept", vm[0], 64'hDEAD);
        finish_resp(0, "hold2");

        // reset during WAIT of pushq 0x8 <- 0x77
        icode = 4'hA; valA = 64'h77; valE = 64'h8;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        chk("rw_in_wait", {63'd0, ir[0]}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rw_ov", {63'd0, ov[0]}, 64'd0);
        chk("rw_ir", {63'd0, ir[0]}, 64'd1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rw_no_resp", {63'd0, ov[0]}, 64'd0);

        // reset during RESP clears the held response between edges
        start(0, 4'h5, 64'h0, 64'h10, 64'h0, lat);
        chk("rr_valM_pre", vm[0], 64'hDEAD);
        #2 rst = 1'b1;
        #1;
        chk("rr_valM", vm[0], 64'd0);
        chk("rr_dbg", dw[0], 64'd0);
        chk("rr_ov", {63'd0, ov[0]}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        start(0, 4'h5, 64'h0, 64'h8, 64'h0, lat);
        chk("rw_committed", vm[0], 64'h77);
        finish_resp(0, "rw");

        // non-memory op at each latency
        start(0, 4'h6, 64'h10, 64'h10, 64'h10, lat);
        chk("op2_lat", 64'(lat), 64'd2);
        chk("op2_valM", vm[0], 64'd0);
        chk("op2_err", {63'd0, me[0]}, 64'd0);
        chk("op2_dbg", dw[0], 64'd0);
        chk("op2_icode", {60'd0, oi[0]}, 64'h6);
        finish_resp(0, "op2");

        start(1, 4'h6, 64'h10, 64'h10, 64'h10, lat);
        chk("op1_lat", 64'(lat), 64'd1);
        chk("op1_valM", vm[1], 64'd0);
        chk("op1_err", {63'd0, me[1]}, 64'd0);
        finish_resp(1, "op1");
        start(1, 4'h4, 64'h55, 64'h18, 64'h0, lat);
        chk("l1_wr_dbg", dw[1], 64'h55);
        finish_resp(1, "l1w");
        start(1, 4'h5, 64'h0, 64'h18, 64'h0, lat);
        chk("l1_rd_valM", vm[1], 64'h55);
        finish_resp(1, "l1r");

        start(2, 4'h6, 64'h10, 64'h10, 64'h10, lat);
        chk("op8_lat", 64'(lat), 64'd8);
        chk("op8_valM", vm[2], 64'd0);
        chk("op8_err", {63'd0, me[2]}, 64'd0);
        finish_resp(2, "op8");
        start(2, 4'h4, 64'h99, 64'h20, 64'h0, lat);
        finish_resp(2, "l8w");
        start(2, 4'h5, 64'h0, 64'h20, 64'h0, lat);
        chk("l8_rd_lat", 64'(lat), 64'd8);
        chk("l8_rd_valM", vm[2], 64'h99);
        finish_resp(2, "l8r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
